// File: rtl/writeback_regfile_pkg.sv
// rtl/writeback_regfile_pkg.sv - shared widths and link-register index for the writeback register file
package writeback_regfile_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int LINK_REG   = 31;
endpackage

// File: rtl/wb_select.sv
// rtl/wb_select.sv - combinational writeback data/index select and qualified write strobe
module wb_select
  import writeback_regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              WBmemtoreg,
  input  logic              WBregwrite,
  input  logic              WBcntrljalr,
  input  logic              WBcntrljald,
  input  logic [DATA_W-1:0] WBPCAddResult,
  input  logic [DATA_W-1:0] WBAluResult,
  input  logic [DATA_W-1:0] WBReadData,
  input  logic [ADDR_W-1:0] WBRegDst,
  output logic [DATA_W-1:0] WBWriteData,
  output logic [ADDR_W-1:0] WBWriteReg,
  output logic              WBWriteEn
);
  // Link writes win over load data, which wins over the ALU result.
  always_comb begin
    WBWriteData = WBAluResult;
    if (WBcntrljald || WBcntrljalr)
      WBWriteData = WBPCAddResult;
    else if (WBmemtoreg)
      WBWriteData = WBReadData;
  end

  assign WBWriteReg = WBcntrljald ? ADDR_W'(LINK_REG) : WBRegDst;
  assign WBWriteEn  = WBregwrite && (WBWriteReg != '0);
endmodule

// File: rtl/writeback_regfile.sv
// rtl/writeback_regfile.sv - register file with writeback port; WB_BYPASS_EN enables same-cycle write-through
module writeback_regfile
  import writeback_regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              WBmemtoreg,
  input  logic              WBregwrite,
  input  logic              WBcntrljalr,
  input  logic              WBcntrljald,
  input  logic [DATA_W-1:0] WBPCAddResult,
  input  logic [DATA_W-1:0] WBAluResult,
  input  logic [DATA_W-1:0] WBReadData,
  input  logic [ADDR_W-1:0] WBRegDst,
  input  logic [ADDR_W-1:0] ReadReg1,
  input  logic [ADDR_W-1:0] ReadReg2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  output logic [DATA_W-1:0] WBWriteData,
  output logic [ADDR_W-1:0] WBWriteReg,
  output logic              WBWriteEn
);
  localparam int NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [NREGS];

  wb_select #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_wb_select (
    .WBmemtoreg    (WBmemtoreg),
    .WBregwrite    (WBregwrite),
    .WBcntrljalr   (WBcntrljalr),
    .WBcntrljald   (WBcntrljald),
    .WBPCAddResult (WBPCAddResult),
    .WBAluResult   (WBAluResult),
    .WBReadData    (WBReadData),
    .WBRegDst      (WBRegDst),
    .WBWriteData   (WBWriteData),
    .WBWriteReg    (WBWriteReg),
    .WBWriteEn     (WBWriteEn)
  );

  // WBWriteEn already excludes index 0, so regs[0] is never written after reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < NREGS; i++)
        regs[i] <= '0;
    end else if (WBWriteEn) begin
      regs[WBWriteReg] <= WBWriteData;
    end
  end

  always_comb begin
    ReadData1 = (ReadReg1 == '0) ? '0 : regs[ReadReg1];
    ReadData2 = (ReadReg2 == '0) ? '0 : regs[ReadReg2];
`ifdef WB_BYPASS_EN
    if (!Reset && WBWriteEn && (ReadReg1 == WBWriteReg))
      ReadData1 = WBWriteData;
    if (!Reset && WBWriteEn && (ReadReg2 == WBWriteReg))
      ReadData2 = WBWriteData;
`endif
  end
endmodule

// File: tb/tb_writeback_regfile.sv
// tb/tb_writeback_regfile.sv - directed self-checking bench for writeback_regfile
module tb_writeback_regfile;
  logic        Clk = 1'b0;
  logic        Reset, WBmemtoreg, WBregwrite, WBcntrljalr, WBcntrljald;
  logic [31:0] WBPCAddResult, WBAluResult, WBReadData;
  logic [4:0]  WBRegDst, ReadReg1, ReadReg2;
  logic [31:0] ReadData1, ReadData2, WBWriteData;
  logic [4:0]  WBWriteReg;
  logic        WBWriteEn;
  int checks = 0;
  int failures = 0;

  writeback_regfile #(.DATA_W(32), .ADDR_W(5)) dut (
    .Clk(Clk), .Reset(Reset), .WBmemtoreg(WBmemtoreg), .WBregwrite(WBregwrite),
    .WBcntrljalr(WBcntrljalr), .WBcntrljald(WBcntrljald), .WBPCAddResult(WBPCAddResult),
    .WBAluResult(WBAluResult), .WBReadData(WBReadData), .WBRegDst(WBRegDst),
    .ReadReg1(ReadReg1), .ReadReg2(ReadReg2), .ReadData1(ReadData1), .ReadData2(ReadData2),
    .WBWriteData(WBWriteData), .WBWriteReg(WBWriteReg), .WBWriteEn(WBWriteEn)
  );

  always #5 Clk = ~Clk;

  task automatic drive(input logic rw, input logic mtr, input logic jr, input logic jd,
                       input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] rd,
                       input logic [4:0] dst);
    @(negedge Clk);
    WBregwrite = rw; WBmemtoreg = mtr; WBcntrljalr = jr; WBcntrljald = jd;
    WBPCAddResult = pc; WBAluResult = alu; WBReadData = rd; WBRegDst = dst;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0);
  endtask

  task automatic tick();
    @(posedge Clk); #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    idle();
    tick();
    Reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      ReadReg1 = 5'(i); ReadReg2 = 5'(31 - i); #1;
      checks++;
      if (ReadData1 !== 32'h0) begin failures++; $display("FAIL reset_rd1 idx=%0d got=%h exp=0", i, ReadData1); end
      checks++;
      if (ReadData2 !== 32'h0) begin failures++; $display("FAIL reset_rd2 idx=%0d got=%h exp=0", 31 - i, ReadData2); end
    end
  endtask

  task automatic test_alu_write();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h9999_0000, 32'h0000_1234, 32'h5555_0000, 5'd5);
    #1;
    checks++;
    if (WBWriteData !== 32'h0000_1234 || WBWriteReg !== 5'd5 || WBWriteEn !== 1'b1) begin
      failures++; $display("FAIL alu_select got=%h/%0d/%b exp=00001234/5/1", WBWriteData, WBWriteReg, WBWriteEn);
    end
    tick();
    idle();
    ReadReg1 = 5'd5; ReadReg2 = 5'd5; #1;
    checks++;
    if (ReadData1 !== 32'h0000_1234) begin failures++; $display("FAIL alu_write_rd1 got=%h exp=00001234", ReadData1); end
    checks++;
    if (ReadData2 !== ReadData1) begin failures++; $display("FAIL same_index_ports got=%h exp=%h", ReadData2, ReadData1); end
  endtask

  task automatic test_link();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_0077, 32'h0, 5'd7);
    tick();
    drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h0040_0008, 32'h1111_1111, 32'h2222_2222, 5'd7);
    #1;
    checks++;
    if (WBWriteReg !== 5'd31 || WBWriteData !== 32'h0040_0008) begin
      failures++; $display("FAIL jald_select got=%0d/%h exp=31/00400008", WBWriteReg, WBWriteData);
    end
    tick();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0040_0010, 32'h1111_1111, 32'h2222_2222, 5'd9);
    tick();
    idle();
    ReadReg1 = 5'd31; ReadReg2 = 5'd7; #1;
    checks++;
    if (ReadData1 !== 32'h0040_0008) begin failures++; $display("FAIL jald_reg31 got=%h exp=00400008", ReadData1); end
    checks++;
    if (ReadData2 !== 32'h0000_0077) begin failures++; $display("FAIL jald_reg7_kept got=%h exp=00000077", ReadData2); end
    ReadReg1 = 5'd9; #1;
    checks++;
    if (ReadData1 !== 32'h0040_0010) begin failures++; $display("FAIL jalr_reg9 got=%h exp=00400010", ReadData1); end
  endtask

  task automatic test_reg0_and_disable();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'hDEAD_BEEF, 5'd0);
    #1;
    checks++;
    if (WBWriteEn !== 1'b0 || WBWriteData !== 32'hDEAD_BEEF) begin
      failures++; $display("FAIL reg0_strobe got=%b/%h exp=0/deadbeef", WBWriteEn, WBWriteData);
    end
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'hFFFF_FFFF, 32'h0, 5'd5);
    #1;
    checks++;
    if (WBWriteEn !== 1'b0) begin failures++; $display("FAIL regwrite_off_strobe got=%b exp=0", WBWriteEn); end
    tick();
    idle();
    ReadReg1 = 5'd0; ReadReg2 = 5'd5; #1;
    checks++;
    if (ReadData1 !== 32'h0) begin failures++; $display("FAIL reg0_read got=%h exp=0", ReadData1); end
    checks++;
    if (ReadData2 !== 32'h0000_1234) begin failures++; $display("FAIL regwrite_off_reg5 got=%h exp=00001234", ReadData2); end
  endtask

  task automatic test_same_cycle();
    logic [31:0] exp_now;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h1111_0000, 32'h0, 5'd3);
    tick();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'hA5A5_A5A5, 32'h0, 5'd3);
    ReadReg2 = 5'd3; ReadReg1 = 5'd5; #1;
`ifdef WB_BYPASS_EN
    exp_now = 32'hA5A5_A5A5;
`else
    exp_now = 32'h1111_0000;
`endif
    checks++;
    if (ReadData2 !== exp_now) begin failures++; $display("FAIL same_cycle_rd2 got=%h exp=%h", ReadData2, exp_now); end
    checks++;
    if (ReadData1 !== 32'h0000_1234) begin failures++; $display("FAIL same_cycle_other_port got=%h exp=00001234", ReadData1); end
    tick();
    idle();
    #1;
    checks++;
    if (ReadData2 !== 32'hA5A5_A5A5) begin failures++; $display("FAIL next_cycle_rd2 got=%h exp=a5a5a5a5", ReadData2); end
  endtask

  task automatic test_reset_priority();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_0055, 32'h0, 5'd4);
    tick();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_0001, 32'h0, 5'd4);
    Reset = 1'b1; ReadReg1 = 5'd4; #1;
    checks++;
    if (WBWriteEn !== 1'b1 || WBWriteData !== 32'h1 || WBWriteReg !== 5'd4) begin
      failures++; $display("FAIL reset_comb_outputs got=%b/%h/%0d exp=1/00000001/4", WBWriteEn, WBWriteData, WBWriteReg);
    end
    checks++;
    if (ReadData1 !== 32'h0000_0055) begin failures++; $display("FAIL reset_no_bypass got=%h exp=00000055", ReadData1); end
    tick();
    Reset = 1'b0;
    idle();
    #1;
    checks++;
    if (ReadData1 !== 32'h0) begin failures++; $display("FAIL reset_over_write got=%h exp=0", ReadData1); end
    ReadReg2 = 5'd3; #1;
    checks++;
    if (ReadData2 !== 32'h0) begin failures++; $display("FAIL reset_clears_reg3 got=%h exp=0", ReadData2); end
  endtask

  initial begin
    Reset = 1'b0; ReadReg1 = '0; ReadReg2 = '0;
    WBregwrite = 1'b0; WBmemtoreg = 1'b0; WBcntrljalr = 1'b0; WBcntrljald = 1'b0;
    WBPCAddResult = '0; WBAluResult = '0; WBReadData = '0; WBRegDst = '0;
    test_reset();
    test_alu_write();
    test_link();
    test_reg0_and_disable();
    test_same_cycle();
    test_reset_priority();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/writeback_regfile.md
WRITEBACK_REGFILE -- requirements
Module: writeback_regfile

Interface
REQ-001 The block SHALL have the following parameter: DATA_W, default 32, datapath width.
REQ-002 The block SHALL have the following parameter: ADDR_W, default 5, register index width (2^ADDR_W registers).
REQ-003 One clock; reset is synchronous and active-high: the block SHALL have port Clk, input, 1 bit, rising-edge clock.
REQ-004 The block SHALL have port Reset, input, 1 bit, synchronous, active-high.
REQ-005 The block SHALL have port WBmemtoreg, input, 1 bit, select load data.
REQ-006 The block SHALL have port WBregwrite, input, 1 bit, write enable.
REQ-007 The block SHALL have ports WBcntrljalr and WBcntrljald, input, 1 bit each, link-write selects.
REQ-008 The block SHALL have ports WBPCAddResult, WBAluResult and WBReadData, input, DATA_W each, writeback candidates.
REQ-009 The block SHALL have port WBRegDst, input, ADDR_W, destination index.
REQ-010 The block SHALL have ports ReadReg1 and ReadReg2, input, ADDR_W each, decode-stage read indices.
REQ-011 The block SHALL have ports ReadData1 and ReadData2, output, DATA_W each, read data.
REQ-012 The block SHALL have ports WBWriteData (DATA_W) and WBWriteReg (ADDR_W), output, selected write data and index, for the forwarding unit.
REQ-013 The block SHALL have port WBWriteEn, output, 1 bit, qualified write strobe.

Function
REQ-014 Data select SHALL be combinational, priority order: WBcntrljald or WBcntrljalr -> WBPCAddResult; else WBmemtoreg -> WBReadData; else WBAluResult.
REQ-015 Write index SHALL be 31 when WBcntrljald=1, regardless of WBRegDst; otherwise WBRegDst.
REQ-016 WBWriteEn SHALL equal WBregwrite AND (WBWriteReg != 0).
REQ-017 On a rising Clk with WBWriteEn=1 and Reset=0, the register at WBWriteReg SHALL take WBWriteData; the new value SHALL be visible on read ports from the next cycle (1-cycle write latency).
REQ-018 Read ports SHALL be asynchronous (combinational from index and array).
REQ-019 Register 0 SHALL read 0 always; writes to index 0 SHALL be discarded.
REQ-020 WBregwrite=0 SHALL leave all registers unchanged regardless of other inputs.
REQ-021 Both read ports addressing the same index SHALL return identical data.

Reset
REQ-022 While Reset=1 at a rising Clk, all registers SHALL clear to 0; Reset SHALL take priority over a simultaneous write.
REQ-023 After reset, ReadData1 and ReadData2 SHALL be 0 for every index until written.
REQ-024 WBWriteData, WBWriteReg and WBWriteEn SHALL remain purely combinational from their inputs, unaffected by Reset.

Configuration
REQ-025 Macro WB_BYPASS_EN defined: when WBWriteEn=1 and ReadRegN == WBWriteReg (nonzero), ReadDataN SHALL return WBWriteData in the same cycle (write-through); Reset=1 SHALL suppress the bypass.
REQ-026 Macro WB_BYPASS_EN undefined: reads SHALL return stored array contents only; same-cycle writes SHALL be seen the following cycle.

Structure
REQ-027 The shared package SHALL hold DATA_W and ADDR_W defaults and the link-register index constant (31).
REQ-028 The writeback select SHALL be a sub-module named wb_select (purely combinational); the storage and read ports SHALL reside in writeback_regfile.

Verification
REQ-029 The bench SHALL cover: Reset=1 for 1 cycle, then read all 32 indices -> all 0.
REQ-030 The bench SHALL cover: regwrite=1, memtoreg=0, Alu=0x0000_1234, Dst=5; next cycle ReadReg1=5 -> 0x0000_1234.
REQ-031 The bench SHALL cover: jald=1, PCAdd=0x0040_0008, Dst=7, regwrite=1 -> reg31=0x0040_0008, reg7 unchanged; jalr=1, Dst=9 -> reg9=PCAdd.
REQ-032 The bench SHALL cover: memtoreg=1, ReadData=0xDEAD_BEEF, Dst=0, regwrite=1 -> WBWriteEn=0, reg0 reads 0.
REQ-033 The bench SHALL cover: write 0xA5A5_A5A5 to reg3 with ReadReg2=3 in the same cycle -> ReadData2=0xA5A5_A5A5 that cycle with WB_BYPASS_EN defined, old value without it.
REQ-034 The bench SHALL cover: Reset=1 coincident with a write of 0x1 to reg4 -> reg4 reads 0 afterward.
